dino_hit_detect: RTL and testbench

//  Consumer of the dino height and jump-physics output. Samples dinoY against the current obstacle once per

---
 rtl/dino_hit_detect.sv | 171 +++++++++++++++++
 tb/tb_dino_hit_detect.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dino_hit_detect.sv
// dino_hit_detect: samples the dino height against the current obstacle once per frame
// tick, confirms collisions over HIT_FRAMES ticks, runs the game FSM and keeps a
// saturating 4-digit BCD score.
// Optional feature macro: DINO_HIGHSCORE_EN (keeps a best-score register).
module dino_hit_detect #(
    parameter int FLOOR_Y    = 101,
    parameter int DINO_X     = 20,
    parameter int DINO_W     = 12,
    parameter int OBS_W      = 8,
    parameter int OBS_H      = 15,
    parameter int TICK_DIV   = 400000,
    parameter int HIT_FRAMES = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [7:0]  dinoY,
    input  logic [7:0]  obsX,
    input  logic        obsValid,
    input  logic        restart,
    output logic        gameOver,
    output logic        running,
    output logic        hitPulse,
    output logic [15:0] score,
    output logic [15:0] highScore
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, RUN, CONFIRM, OVER} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     score_q, score_d;
    logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
    logic            hit_pulse_q;
    logic            tick;
    logic            overlap;
    logic            enter_over;
    logic [7:0]      height;
    logic [8:0]      obs_x9;

    // Saturating BCD increment; 9999 holds instead of wrapping to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    // Height above floor clamps to 0 below the floor; x math is 9-bit so obsX+OBS_W cannot wrap.
    assign height  = (dinoY >= 8'(FLOOR_Y)) ? (dinoY - 8'(FLOOR_Y)) : 8'd0;
    assign obs_x9  = {1'b0, obsX};
    assign overlap = obsValid
                  && (obs_x9 < 9'(DINO_X + DINO_W))
                  && ((obs_x9 + 9'(OBS_W)) > 9'(DINO_X))
                  && (height < 8'(OBS_H));

    // Free-running frame tick divider, untouched by restart.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)     cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + CW'(1);
    end

    // Next-state logic; restart beats a same-clk tick in every active state.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            IDLE: begin
                if (restart) begin
                    state_d   = RUN;
                    score_d   = 16'h0000;
                    hit_cnt_d = '0;
                end
            end
            RUN: begin
                if (restart) begin
                    state_d   = RUN;
                    score_d   = 16'h0000;
                    hit_cnt_d = '0;
                end else if (tick) begin
                    if (overlap) begin
                        hit_cnt_d = HW'(1);
                        state_d   = (HIT_FRAMES == 1) ? OVER : CONFIRM;
                    end else begin
                        score_d = bcd_inc(score_q);
                    end
                end
            end
            CONFIRM: begin
                if (restart) begin
                    state_d   = RUN;
                    score_d   = 16'h0000;
                    hit_cnt_d = '0;
                end else if (tick) begin
                    if (overlap) begin
                        hit_cnt_d = hit_cnt_q + HW'(1);
                        if ((hit_cnt_q + HW'(1)) == HW'(HIT_FRAMES)) state_d = OVER;
                    end else begin
                        hit_cnt_d = '0;
                        score_d   = bcd_inc(score_q);
                        state_d   = RUN;
                    end
                end
            end
            OVER: begin
                if (restart) begin
                    state_d   = RUN;
                    score_d   = 16'h0000;
                    hit_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_over = (state_d == OVER) && (state_q != OVER);

    // Game state, score and hit counter registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            score_q     <= 16'h0000;
            hit_cnt_q   <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_pulse_q <= enter_over;
        end
    end

`ifdef DINO_HIGHSCORE_EN
    logic [15:0] hs_q;

    // Best score latched on game end; BCD digits compare correctly as binary.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                               hs_q <= 16'h0000;
        else if (enter_over && (score_q > hs_q)) hs_q <= score_q;
    end

    assign highScore = hs_q;
`else
    assign highScore = 16'h0000;
`endif

    assign gameOver = (state_q == OVER);
    assign running  = (state_q == RUN) || (state_q == CONFIRM);
    assign hitPulse = hit_pulse_q;
    assign score    = score_q;

endmodule

// File: tb/tb_dino_hit_detect.sv
// Directed bench for dino_hit_detect with TICK_DIV=4, HIT_FRAMES=2.
module tb_dino_hit_detect;

    localparam int TD = 4;
`ifdef DINO_HIGHSCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [7:0]  dinoY = 8'd101;
    logic [7:0]  obsX = 8'd100;
    logic        obsValid = 1'b0;
    logic        restart = 1'b0;
    logic        gameOver, running, hitPulse;
    logic [15:0] score, highScore;

    int n_chk = 0;
    int n_fail = 0;
    int tb_cnt;
    int es;

    dino_hit_detect #(.TICK_DIV(TD), .HIT_FRAMES(2)) dut (
        .clk(clk), .nRst(nRst), .dinoY(dinoY), .obsX(obsX), .obsValid(obsValid),
        .restart(restart), .gameOver(gameOver), .running(running), .hitPulse(hitPulse),
        .score(score), .highScore(highScore)
    );

    always #5 clk = ~clk;

    // Bench-side copy of the frame divider phase, used only to know when ticks land.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance through n tick edges; returns 1 time unit after the last one.
    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            while (tb_cnt != TD - 1) @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    task automatic set_obs(input logic v, input logic [7:0] x, input logic [7:0] y);
        obsValid = v;
        obsX     = x;
        dinoY    = y;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Boundary vectors: obsValid, obsX, dinoY, expected overlap.
    logic       bv_v [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [7:0] bv_x [9] = '{12, 13, 31, 32, 25, 25, 25, 25, 250};
    logic [7:0] bv_y [9] = '{101, 101, 101, 101, 115, 116, 50, 101, 101};
    logic       bv_o [9] = '{0, 1, 1, 0, 1, 0, 1, 0, 0};

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then idle
        #12 nRst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_score", score, 16'h0000);
        check("idle_over", gameOver, 1'b0);
        check("idle_run", running, 1'b0);
        check("idle_pulse", hitPulse, 1'b0);
        check("idle_hs", highScore, 16'h0000);

        // 2: ten clean ticks
        pulse_restart();
        check("start_run", running, 1'b1);
        tick_n(10);
        check("ten_ticks", score, 16'h0010);

        // 3: two overlapping ticks end the game
        set_obs(1'b1, 8'd25, 8'd101);
        tick_n(1);
        check("confirm_run", running, 1'b1);
        check("confirm_over", gameOver, 1'b0);
        check("confirm_score", score, 16'h0010);
        tick_n(1);
        check("hit_over", gameOver, 1'b1);
        check("hit_pulse", hitPulse, 1'b1);
        check("hit_run", running, 1'b0);
        @(posedge clk); #1;
        check("pulse_drop", hitPulse, 1'b0);
        set_obs(1'b0, 8'd100, 8'd101);
        tick_n(3);
        check("frozen_score", score, 16'h0010);
        check("hs_game0", highScore, HS ? 16'h0010 : 16'h0000);

        // 4: single overlap then clear returns to RUN
        pulse_restart();
        check("restart_score", score, 16'h0000);
        check("restart_over", gameOver, 1'b0);
        set_obs(1'b1, 8'd25, 8'd101);
        tick_n(1);
        check("one_hit_score", score, 16'h0000);
        dinoY = 8'd120;
        tick_n(1);
        check("cleared_score", score, 16'h0001);
        check("cleared_over", gameOver, 1'b0);

        // Hitbox and height boundaries; each vector followed by a clean tick.
        es = 1;
        for (int i = 0; i < 9; i++) begin
            set_obs(bv_v[i], bv_x[i], bv_y[i]);
            tick_n(1);
            if (!bv_o[i]) es++;
            check($sformatf("bound%0d", i), score, to_bcd(es));
            set_obs(1'b0, 8'd100, 8'd101);
            tick_n(1);
            es++;
        end
        check("bound_over", gameOver, 1'b0);

        // Inputs changed only between ticks are ignored.
        while (tb_cnt != 1) @(negedge clk);
        set_obs(1'b1, 8'd25, 8'd101);
        @(negedge clk);
        set_obs(1'b0, 8'd100, 8'd101);
        tick_n(1);
        es++;
        check("offtick_ignored", score, to_bcd(es));

        // Restart on the tick clk wins over the score increment.
        while (tb_cnt != TD - 1) @(negedge clk);
        restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        check("restart_prio", score, 16'h0000);

        // 6: two games, best score kept
        set_obs(1'b0, 8'd100, 8'd101);
        pulse_restart();
        tick_n(42);
        set_obs(1'b1, 8'd25, 8'd101);
        tick_n(2);
        check("g1_over", gameOver, 1'b1);
        check("g1_score", score, 16'h0042);
        check("g1_hs", highScore, HS ? 16'h0042 : 16'h0000);
        set_obs(1'b0, 8'd100, 8'd101);
        pulse_restart();
        tick_n(17);
        set_obs(1'b1, 8'd25, 8'd101);
        tick_n(2);
        check("g2_score", score, 16'h0017);
        check("g2_hs", highScore, HS ? 16'h0042 : 16'h0000);

        // Async reset mid-game
        set_obs(1'b0, 8'd100, 8'd101);
        pulse_restart();
        tick_n(3);
        @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        check("arst_run", running, 1'b0);
        check("arst_score", score, 16'h0000);
        check("arst_hs", highScore, 16'h0000);
        #5 nRst = 1'b1;

        // 5: BCD carries and saturation
        pulse_restart();
        tick_n(100);
        check("bcd_100", score, 16'h0100);
        tick_n(9898);
        check("bcd_9998", score, 16'h9998);
        tick_n(1);
        check("sat_9999", score, 16'h9999);
        tick_n(2);
        check("sat_hold", score, 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
